// File: rtl/spi_master_reg_access_if.sv
// Command/response bundle between a register-access requester and the SPI master.
// The master modport is the requester side; the slave modport is the SPI master block.
interface spi_master_reg_access_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [13:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/spi_master_reg_access.sv
// SPI mode-0 register-access master (two 16-bit frames); SPI_MASTER_WRITE_VERIFY_EN adds write readback/compare.
// Latency 68*CLK_DIV+2*FRAME_GAP+1 clks (doubled for verified writes); cmd_ready low while busy, rsp is a pulse.
module spi_master_reg_access #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned FRAME_GAP = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_master_reg_access_if.slave        bus,
    output logic                          spi_cs_n,
    output logic                          spi_sclk,
    output logic                          spi_mosi,
    input  logic                          spi_miso
);
    localparam int unsigned       CNT_W    = 11;
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(FRAME_GAP - 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP1, GAP2, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic               sclk_ph_q, sclk_ph_d;
    logic               frame_q, frame_d;
    logic [15:0]        tx_q, tx_d, rx_q, rx_d;
    logic               rw_q, rw_d;
    logic [13:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               cmd_ready_q, cmd_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_rdata_q, rsp_rdata_d;
    logic               cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic               rd_pass;
    logic               div_last;

`ifdef SPI_MASTER_WRITE_VERIFY_EN
    logic               vfy_q, vfy_d, rsp_err_q, rsp_err_d;
    assign rd_pass = rw_q | vfy_q;
`else
    assign rd_pass = rw_q;
`endif

    assign div_last = (cnt_q == DIV_LAST);

    // Pin and response registers follow the current state, so they trail it by one clk.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sclk_ph_d   = sclk_ph_q;
        frame_d     = frame_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        cs_n_d      = 1'b1;
        sclk_d      = 1'b0;
        mosi_d      = 1'b0;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
        vfy_d       = vfy_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    rw_d    = bus.cmd_rw;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    tx_d    = {{2{bus.cmd_rw}}, bus.cmd_addr};
                    frame_d = 1'b0;
                    cnt_d   = '0;
                    state_d = CS_SETUP;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
                    vfy_d   = 1'b0;
`endif
                end
            end
            CS_SETUP: begin
                cs_n_d = 1'b0;
                mosi_d = tx_q[15];
                if (div_last) begin
                    cnt_d     = '0;
                    sclk_ph_d = 1'b1;
                    bit_d     = 4'd15;
                    state_d   = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                cs_n_d = 1'b0;
                mosi_d = tx_q[15];
                sclk_d = sclk_ph_q;
                if (sclk_ph_q && cnt_q == '0) begin
                    rx_d = {rx_q[14:0], spi_miso};
                end
                if (div_last) begin
                    cnt_d = '0;
                    if (sclk_ph_q) begin
                        sclk_ph_d = 1'b0;
                        if (bit_q != 4'd0) begin
                            tx_d = {tx_q[14:0], 1'b0};
                        end
                    end else if (bit_q == 4'd0) begin
                        state_d = CS_HOLD;
                    end else begin
                        sclk_ph_d = 1'b1;
                        bit_d     = bit_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CS_HOLD: begin
                cs_n_d = 1'b0;
                mosi_d = tx_q[15];
                if (div_last) begin
                    cnt_d   = '0;
                    state_d = frame_q ? GAP2 : GAP1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP1: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    frame_d = 1'b1;
                    tx_d    = rd_pass ? 16'h0000 : wdata_q;
                    state_d = CS_SETUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP2: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
                    // A completed write is followed by a readback of the same address.
                    if (!rw_q && !vfy_q) begin
                        vfy_d   = 1'b1;
                        frame_d = 1'b0;
                        tx_d    = {2'b11, addr_q};
                        state_d = CS_SETUP;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                rsp_valid_d = 1'b1;
                if (rd_pass) begin
                    rsp_rdata_d = rx_q;
                end
`ifdef SPI_MASTER_WRITE_VERIFY_EN
                rsp_err_d = vfy_q && (rx_q != wdata_q);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);
        busy_d      = !cmd_ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sclk_ph_q   <= 1'b0;
            frame_q     <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sclk_ph_q   <= sclk_ph_d;
            frame_q     <= frame_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
        end
    end

`ifdef SPI_MASTER_WRITE_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vfy_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            vfy_q     <= vfy_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign spi_cs_n      = cs_n_q;
    assign spi_sclk      = sclk_q;
    assign spi_mosi      = mosi_q;
endmodule

// File: doc/spi_master_reg_access.md
Name: spi_master_reg_access

Overview:
- SPI mode-0 master that issues register transactions to the CPLD SPI slave register file.
- Each transaction is two 16-bit frames: an address frame {rw[1:0], addr[13:0]}, then a data frame.
  - rw = 2'b00 is a write; rw = 2'b11 is a read.
- Sits in the host-side controller (or a test harness) between a simple command/response interface and the SPI pins.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
- FRAME_GAP, 64: clk cycles CS_n is held high between the two frames, and again after the data frame; legal range 1..2000. Must stay well below the slave frame-lost time of 2400 clks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; handshake on cmd_valid & cmd_ready
- cmd_rw  in  1  0 = write, 1 = read
- cmd_addr  in  14  register address
- cmd_wdata  in  16  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse at transaction end
- rsp_rdata  out  16  read data; held until the next rsp_valid
- rsp_err  out  1  verify mismatch, valid with rsp_valid; constant 0 when the optional feature is off
- busy  out  1  high from handshake until rsp_valid, inclusive
- spi_cs_n  out  1  chip select, active low
- spi_sclk  out  1  SPI clock, idle low
- spi_mosi  out  1  master out, MSB first
- spi_miso  in  1  master in; sampled directly, board guarantees sync/timing

Behaviour:
- Reset values: cmd_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, spi_cs_n 1, spi_sclk 0, spi_mosi 0. All outputs are registered.
- Command capture: on handshake, latch cmd_rw, cmd_addr and cmd_wdata.
  - shift word A = {cmd_rw ? 2'b11 : 2'b00, cmd_addr}.
  - shift word D = cmd_rw ? 16'h0000 : cmd_wdata.
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP1, (second frame: CS_SETUP, SHIFT, CS_HOLD), GAP2, DONE. A frame-select bit distinguishes the A and D passes.
- Frame timing: one CLK_DIV-cycle counter and a 4-bit bit counter.
  - CS_SETUP: spi_cs_n is low and spi_mosi = bit15 for CLK_DIV cycles.
  - SHIFT, per bit: spi_sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - spi_miso is sampled into the rx shift register on the rising SCLK edge.
  - spi_mosi advances to the next bit on each falling edge, except after bit 0.
  - CS_HOLD: CLK_DIV cycles with SCLK low, then spi_cs_n returns high.
  - spi_cs_n is low for exactly 34*CLK_DIV cycles per frame.
  - spi_mosi returns to 0 while CS_n is high.
- Gaps: GAP1 and GAP2 each last FRAME_GAP cycles with CS_n high and SCLK low.
- Completion, in DONE (1 cycle):
  - rsp_valid = 1.
  - For reads, rsp_rdata = data-frame rx word. rsp_rdata is unchanged after writes.
  - Next cycle: IDLE and cmd_ready = 1.
- Latency: handshake edge to rsp_valid-high cycle = 68*CLK_DIV + 2*FRAME_GAP + 1 clks.
- cmd_valid is ignored while busy. Back-to-back commands are accepted the cycle after rsp_valid.
- Mid-operation reset: all outputs return immediately to reset values, the transaction is dropped, and no rsp_valid is produced. The slave's own frame-lost timeout recovers its side.
- The rx shift register is 16 bits. The address-frame MISO content is discarded.

Optional Feature:
- Macro: SPI_MASTER_WRITE_VERIFY_EN.
- When defined:
  - After a write's GAP2, the block automatically issues a read transaction to the same address: address frame 0xC000|addr, same timing.
  - The readback word is compared to cmd_wdata; rsp_err = 1 on mismatch.
  - rsp_rdata = readback word.
  - rsp_valid is produced once, at the end of the readback.
  - Write latency doubles: 2*(68*CLK_DIV + 2*FRAME_GAP) + 1.
  - Reads are unaffected.
- When undefined: rsp_err is tied 0 and no readback logic exists.

Test Plan (CLK_DIV=4, FRAME_GAP=64; slave bench model):
- Write addr 0x0011, data 0x05DC -> MOSI frames 0x0011 then 0x05DC; each CS_n low 136 clks; 16 SCLK rises per frame; rsp_valid exactly 401 clks after handshake; model reg 0x11 = 0x05DC.
- Read addr 0x001D, model returns 0x1234 -> MOSI 0xC01D then 0x0000; rsp_rdata = 0x1234; rsp_err = 0.
- Two commands back-to-back (cmd_valid held high) -> second handshake in the cycle after the first rsp_valid; CS_n high ≥ 64 clks between transactions; cmd_valid changes while busy are ignored.
- rst_n pulsed low during bit 7 of the data frame -> spi_cs_n = 1, spi_sclk = 0, cmd_ready = 1 immediately; no rsp_valid; the next command completes normally.
- CLK_DIV=2, FRAME_GAP=1 -> 16 SCLK periods of 4 clks each; latency 139 clks.
- SPI_MASTER_WRITE_VERIFY_EN defined, model corrupts the readback to 0x05DD for a write of 0x05DC -> a second transaction with address frame 0xC011 is issued; rsp_err = 1; rsp_rdata = 0x05DD; latency 801 clks.
